// File: rtl/leve2_id.sv
// leve2_id: RISC-V decode/operand-read stage with register file, EX/WB bypass, load-use interlock and stall counter
module leve2_id #(
  parameter int XLEN    = 64,
  parameter int NUM_REG = 32,
  parameter int FWD_EN  = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IVALID,
  output logic            IREADY,
  input  logic [XLEN-1:0] IPC,
  input  logic [31:0]     IINSTR,
  input  logic            FLUSH,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [XLEN-1:0] OPC,
  output logic [31:0]     OINSTR,
  output logic [XLEN-1:0] RS1,
  output logic [XLEN-1:0] RS2,
  output logic            ILLEGAL_REG,
  input  logic            EX_WE,
  input  logic [4:0]      EX_RD,
  input  logic [XLEN-1:0] EX_DATA,
  input  logic            EX_LOAD,
  input  logic            WB_WE,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA,
  output logic [31:0]     STALL_CNT
);
  localparam int AW = 5;
  localparam int RW = $clog2(NUM_REG);
  localparam logic [AW:0] NR = NUM_REG[AW:0];

  logic [XLEN-1:0] r_rf [1:NUM_REG-1];
  logic [AW-1:0]   w_src [2];
  logic [XLEN-1:0] w_op [2];
  logic [1:0]      w_bad;
  logic [AW-1:0]   w_rd;
  logic            w_slot_free, w_ex_haz, w_wb_haz, w_xfer, w_ill;

  assign w_src[0]    = IINSTR[19:15];
  assign w_src[1]    = IINSTR[24:20];
  assign w_rd        = IINSTR[11:7];
  assign w_slot_free = !OVALID || OREADY;
  assign w_ex_haz    = EX_WE && OVALID && EX_RD != '0 &&
                       (EX_RD == w_src[0] || EX_RD == w_src[1]) && (EX_LOAD || FWD_EN == 0);
  assign w_wb_haz    = FWD_EN == 0 && WB_WE && WB_RD != '0 &&
                       (WB_RD == w_src[0] || WB_RD == w_src[1]);
  assign IREADY      = w_slot_free && !w_ex_haz && !w_wb_haz;
  assign w_xfer      = IVALID && IREADY;
  assign w_ill       = |w_bad || {1'b0, w_rd} >= NR;

  // WB match is a same-cycle bypass and applies even with forwarding disabled
  for (genvar g = 0; g < 2; g++) begin : g_op
    assign w_bad[g] = {1'b0, w_src[g]} >= NR;
    assign w_op[g]  = (w_src[g] == '0 || w_bad[g]) ? '0 :
                      (FWD_EN != 0 && OVALID && EX_WE && EX_RD == w_src[g]) ? EX_DATA :
                      (WB_WE && WB_RD == w_src[g]) ? WB_DATA :
                      r_rf[w_src[g][RW-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (WB_WE && WB_RD != '0 && {1'b0, WB_RD} < NR) r_rf[WB_RD[RW-1:0]] <= WB_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVALID      <= 1'b0;
      OPC         <= '0;
      OINSTR      <= '0;
      RS1         <= '0;
      RS2         <= '0;
      ILLEGAL_REG <= 1'b0;
      STALL_CNT   <= '0;
    end else begin
      OVALID <= FLUSH ? 1'b0 : w_slot_free ? w_xfer : OVALID;
      if (w_xfer) begin
        OPC         <= IPC;
        OINSTR      <= IINSTR;
        RS1         <= w_op[0];
        RS2         <= w_op[1];
        ILLEGAL_REG <= w_ill;
      end
      if (IVALID && !IREADY && w_slot_free && STALL_CNT != '1) STALL_CNT <= STALL_CNT + 32'd1;
    end
  end
endmodule

// File: tb/tb_leve2_id.sv
// tb_leve2_id: scenario tasks for leve2_id; a scoreboard queue checks every consumed output slot
module tb_leve2_id;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        IVALID, FLUSH, OREADY, EX_WE, EX_LOAD, WB_WE;
  logic [63:0] IPC, EX_DATA, WB_DATA;
  logic [31:0] IINSTR;
  logic [4:0]  EX_RD, WB_RD;
  logic        a_iready, a_ovalid, a_ill, b_iready, b_ovalid, b_ill;
  logic [63:0] a_opc, a_rs1, a_rs2, b_opc, b_rs1, b_rs2;
  logic [31:0] a_oinstr, a_stall, b_oinstr, b_stall;
  logic        sel;
  logic        m_ovalid, m_iready, m_ill;
  logic [63:0] m_opc, m_rs1, m_rs2;
  int          checks = 0, errors = 0;
  logic [31:0] s0;

  typedef struct {logic [63:0] pc; logic [63:0] r1; logic [63:0] r2; logic ill;} exp_t;
  exp_t q[$];
  exp_t e;

  leve2_id u_a (.CLK(CLK), .RST(RST), .IVALID(IVALID), .IREADY(a_iready), .IPC(IPC), .IINSTR(IINSTR),
    .FLUSH(FLUSH), .OVALID(a_ovalid), .OREADY(OREADY), .OPC(a_opc), .OINSTR(a_oinstr), .RS1(a_rs1),
    .RS2(a_rs2), .ILLEGAL_REG(a_ill), .EX_WE(EX_WE), .EX_RD(EX_RD), .EX_DATA(EX_DATA), .EX_LOAD(EX_LOAD),
    .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .STALL_CNT(a_stall));

  leve2_id #(.NUM_REG(16), .FWD_EN(0)) u_b (.CLK(CLK), .RST(RST), .IVALID(IVALID), .IREADY(b_iready),
    .IPC(IPC), .IINSTR(IINSTR), .FLUSH(FLUSH), .OVALID(b_ovalid), .OREADY(OREADY), .OPC(b_opc),
    .OINSTR(b_oinstr), .RS1(b_rs1), .RS2(b_rs2), .ILLEGAL_REG(b_ill), .EX_WE(EX_WE), .EX_RD(EX_RD),
    .EX_DATA(EX_DATA), .EX_LOAD(EX_LOAD), .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .STALL_CNT(b_stall));

  assign m_ovalid = sel ? b_ovalid : a_ovalid;
  assign m_iready = sel ? b_iready : a_iready;
  assign m_ill    = sel ? b_ill : a_ill;
  assign m_opc    = sel ? b_opc : a_opc;
  assign m_rs1    = sel ? b_rs1 : a_rs1;
  assign m_rs2    = sel ? b_rs2 : a_rs2;

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!RST && m_ovalid && OREADY && !FLUSH) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: unexpected slot pc=%h", m_opc);
      end else begin
        e = q.pop_front();
        if (m_opc !== e.pc || m_rs1 !== e.r1 || m_rs2 !== e.r2 || m_ill !== e.ill) begin
          errors++;
          $display("FAIL sb_out: got pc=%h rs1=%h rs2=%h ill=%b expected pc=%h rs1=%h rs2=%h ill=%b",
                   m_opc, m_rs1, m_rs2, m_ill, e.pc, e.r1, e.r2, e.ill);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b0, rd, 7'h33};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] e1,
                       input logic [63:0] e2, input logic ill);
    q.push_back('{pc, e1, e2, ill});
    IPC = pc;
    IINSTR = ins;
    IVALID = 1'b1;
  endtask

  task automatic wait_accept;
    int n = 0;
    @(negedge CLK);
    while (!m_iready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!m_iready) begin errors++; $display("FAIL accept_timeout: got iready=0 expected 1 within 20 cycles"); end
    tick();
    IVALID = 1'b0;
  endtask

  task automatic drain;
    IVALID = 1'b0; EX_WE = 1'b0; EX_LOAD = 1'b0; WB_WE = 1'b0; FLUSH = 1'b0; OREADY = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    @(negedge CLK);
    checks++; if (a_ovalid !== 1'b0 || b_ovalid !== 1'b0) begin errors++; $display("FAIL rst_ovalid: got %b/%b expected 0", a_ovalid, b_ovalid); end
    checks++; if (a_opc !== '0 || a_oinstr !== '0) begin errors++; $display("FAIL rst_opc: got %h/%h expected 0", a_opc, a_oinstr); end
    checks++; if (a_rs1 !== '0 || a_rs2 !== '0 || a_ill !== 1'b0) begin errors++; $display("FAIL rst_rs: got %h/%h/%b expected 0", a_rs1, a_rs2, a_ill); end
    checks++; if (a_stall !== '0 || b_stall !== '0) begin errors++; $display("FAIL rst_stall: got %0d/%0d expected 0", a_stall, b_stall); end
    tick();
    IVALID = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_wb_read;
    WB_WE = 1'b1; WB_RD = 5'd5; WB_DATA = 64'h1234;
    tick();
    WB_WE = 1'b0;
    offer(64'h100, mk(6, 5, 5), 64'h1234, 64'h1234, 1'b0);
    wait_accept();
    checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL wb_ovalid: got %b expected 1", a_ovalid); end
    checks++; if (a_rs1 !== 64'h1234 || a_rs2 !== 64'h1234) begin errors++; $display("FAIL wb_rs: got %h/%h expected 1234", a_rs1, a_rs2); end
    WB_WE = 1'b1; WB_RD = 5'd8; WB_DATA = 64'h77;
    offer(64'h104, mk(9, 8, 0), 64'h77, 64'h0, 1'b0);
    wait_accept();
    WB_WE = 1'b0;
    checks++; if (a_rs1 !== 64'h77) begin errors++; $display("FAIL wb_bypass: got %h expected 77", a_rs1); end
    offer(64'h108, mk(9, 0, 8), 64'h0, 64'h77, 1'b0);
    wait_accept();
  endtask

  task automatic test_ex_fwd;
    offer(64'h200, mk(7, 0, 0), 64'h0, 64'h0, 1'b0);
    wait_accept();
    s0 = a_stall;
    EX_WE = 1'b1; EX_RD = 5'd7; EX_DATA = 64'hAA; EX_LOAD = 1'b0;
    offer(64'h204, mk(9, 7, 0), 64'hAA, 64'h0, 1'b0);
    @(negedge CLK);
    checks++; if (a_iready !== 1'b1) begin errors++; $display("FAIL fwd_iready: got %b expected 1", a_iready); end
    tick();
    IVALID = 1'b0; EX_WE = 1'b0;
    checks++; if (a_rs1 !== 64'hAA) begin errors++; $display("FAIL fwd_rs1: got %h expected aa", a_rs1); end
    checks++; if (a_stall !== s0) begin errors++; $display("FAIL fwd_stall: got %0d expected %0d", a_stall, s0); end
  endtask

  task automatic test_load_use;
    offer(64'h300, mk(7, 0, 0), 64'h0, 64'h0, 1'b0);
    wait_accept();
    s0 = a_stall;
    EX_WE = 1'b1; EX_RD = 5'd7; EX_LOAD = 1'b1; EX_DATA = 64'hDEAD;
    offer(64'h304, mk(9, 7, 7), 64'h55, 64'h55, 1'b0);
    @(negedge CLK);
    checks++; if (a_iready !== 1'b0) begin errors++; $display("FAIL lu_iready: got %b expected 0", a_iready); end
    tick();
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got ovalid=%b expected 0", a_ovalid); end
    checks++; if (a_stall !== s0 + 32'd1) begin errors++; $display("FAIL lu_stall: got %0d expected %0d", a_stall, s0 + 32'd1); end
    EX_WE = 1'b0; EX_LOAD = 1'b0; WB_WE = 1'b1; WB_RD = 5'd7; WB_DATA = 64'h55;
    @(negedge CLK);
    checks++; if (a_iready !== 1'b1) begin errors++; $display("FAIL lu_resume: got iready=%b expected 1", a_iready); end
    tick();
    IVALID = 1'b0; WB_WE = 1'b0;
    checks++; if (a_ovalid !== 1'b1 || a_rs1 !== 64'h55) begin errors++; $display("FAIL lu_rs1: got v=%b %h expected 1 55", a_ovalid, a_rs1); end
    checks++; if (a_stall !== s0 + 32'd1) begin errors++; $display("FAIL lu_stall2: got %0d expected %0d", a_stall, s0 + 32'd1); end
  endtask

  task automatic test_backpressure;
    offer(64'h400, mk(12, 8, 0), 64'h77, 64'h0, 1'b0);
    wait_accept();
    OREADY = 1'b0;
    s0 = a_stall;
    offer(64'h404, mk(13, 0, 0), 64'h0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (a_iready !== 1'b0) begin errors++; $display("FAIL bp_iready[%0d]: got %b expected 0", i, a_iready); end
      checks++; if (a_ovalid !== 1'b1 || a_opc !== 64'h400 || a_rs1 !== 64'h77) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h rs1=%h expected 1 400 77", i, a_ovalid, a_opc, a_rs1); end
      checks++; if (a_stall !== s0) begin errors++; $display("FAIL bp_stall[%0d]: got %0d expected %0d", i, a_stall, s0); end
      tick();
    end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL flush: got ovalid=%b expected 0", a_ovalid); end
    void'(q.pop_front());
    OREADY = 1'b1;
    wait_accept();
  endtask

  task automatic test_illegal_nofwd;
    drain();
    sel = 1'b1;
    WB_WE = 1'b1; WB_RD = 5'd3; WB_DATA = 64'h300;
    tick();
    WB_WE = 1'b0;
    offer(64'h500, mk(1, 20, 0), 64'h0, 64'h0, 1'b1);
    wait_accept();
    checks++; if (b_ill !== 1'b1 || b_rs1 !== '0) begin errors++; $display("FAIL illegal: got ill=%b rs1=%h expected 1 0", b_ill, b_rs1); end
    offer(64'h504, mk(10, 3, 0), 64'h300, 64'h0, 1'b0);
    wait_accept();
    s0 = b_stall;
    EX_WE = 1'b1; EX_RD = 5'd10; EX_DATA = 64'hBEEF;
    offer(64'h508, mk(11, 10, 0), 64'hBEEF, 64'h0, 1'b0);
    @(negedge CLK);
    checks++; if (b_iready !== 1'b0) begin errors++; $display("FAIL nf_ex_stall: got iready=%b expected 0", b_iready); end
    tick();
    EX_WE = 1'b0; WB_WE = 1'b1; WB_RD = 5'd10; WB_DATA = 64'hBEEF;
    @(negedge CLK);
    checks++; if (b_iready !== 1'b0) begin errors++; $display("FAIL nf_wb_stall: got iready=%b expected 0", b_iready); end
    tick();
    WB_WE = 1'b0;
    @(negedge CLK);
    checks++; if (b_iready !== 1'b1) begin errors++; $display("FAIL nf_resume: got iready=%b expected 1", b_iready); end
    tick();
    IVALID = 1'b0;
    checks++; if (b_rs1 !== 64'hBEEF || b_ill !== 1'b0) begin errors++; $display("FAIL nf_rs1: got %h ill=%b expected beef 0", b_rs1, b_ill); end
    checks++; if (b_stall !== s0 + 32'd2) begin errors++; $display("FAIL nf_stall: got %0d expected %0d", b_stall, s0 + 32'd2); end
  endtask

  task automatic test_reset_mid;
    drain();
    sel = 1'b0;
    OREADY = 1'b0;
    offer(64'h600, mk(1, 0, 0), 64'h0, 64'h0, 1'b0);
    wait_accept();
    #2 RST = 1'b1;
    #1;
    checks++; if (a_ovalid !== 1'b0 || a_stall !== '0) begin errors++; $display("FAIL rst_mid: got v=%b stall=%0d expected 0 0", a_ovalid, a_stall); end
    q.delete();
    tick();
    RST = 1'b0;
    OREADY = 1'b1;
    offer(64'h608, mk(2, 8, 0), 64'h77, 64'h0, 1'b0);
    @(negedge CLK);
    checks++; if (a_iready !== 1'b1) begin errors++; $display("FAIL rst_first: got iready=%b expected 1", a_iready); end
    tick();
    IVALID = 1'b0;
    checks++; if (a_ovalid !== 1'b1 || a_opc !== 64'h608) begin errors++; $display("FAIL rst_xfer: got v=%b pc=%h expected 1 608", a_ovalid, a_opc); end
  endtask

  initial begin
    sel = 1'b0; IVALID = 1'b1; IPC = 64'hFFFF; IINSTR = 32'hFFFF_FFFF; FLUSH = 1'b0; OREADY = 1'b1;
    EX_WE = 1'b0; EX_RD = '0; EX_DATA = '0; EX_LOAD = 1'b0; WB_WE = 1'b0; WB_RD = '0; WB_DATA = '0;
    test_reset();
    test_wb_read();
    test_ex_fwd();
    test_load_use();
    test_backpressure();
    test_illegal_nofwd();
    test_reset_mid();
    repeat (2) tick();
    checks++; if (q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
